rename_regfile: RTL and testbench
=================================

# rename_regfile

- Parametrised architectural register file with a per-register rename tag table for the Tomasulo/ROB core.
- Generalises the existing two-read-port register file:
  - configurable data width, register count, tag width and read-port count;
  - a one-cycle flush of all rename tags on mispredict/exception recovery;
  - a busy flag per read port;
  - hard-wired x0;
  - optional same-cycle commit bypass.
- Sits between the decoder (source lookup, destination rename) and the ROB commit stage (architectural write-back).

## Interface
- DATA_W, 32, register data width
- REG_AW, 5, register index width; REG_CNT = 2**REG_AW registers
- TAG_W, 4, rename tag width (ROB index + 1)
- TAG_FREE, 0, tag value meaning "not renamed"; ROB never issues it
- NREAD, 2, number of read ports
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  clear all rename tags (pipeline recovery)
- commit_en  in  1  ROB commit write valid
- commit_reg  in  REG_AW  committed destination register
- commit_data  in  DATA_W  committed value
- commit_tag  in  TAG_W  ROB tag of committing instruction
- rename_en  in  1  decoder rename valid
- rename_reg  in  REG_AW  renamed destination register
- rename_tag  in  TAG_W  new producer tag
- rd_name  in  NREAD*REG_AW  read indices, port p at [p*REG_AW +: REG_AW]
- rd_data  out  NREAD*DATA_W  register values
- rd_tag  out  NREAD*TAG_W  producer tags (TAG_FREE if none)
- rd_busy  out  NREAD  1 when rd_tag != TAG_FREE

## Operation
- State:
  - data[REG_CNT] of DATA_W bits;
  - tag[REG_CNT] of TAG_W bits.
- Reset (rst=1 at edge):
  - all data cleared to 0;
  - all tags set to TAG_FREE;
  - commit, rename and flush ignored.
- Read outputs are combinational. While rst=1: rd_data=0, rd_tag=TAG_FREE, rd_busy=0 on all ports.
- Register 0:
  - reads always return data 0, TAG_FREE, busy 0;
  - commits and renames to register 0 are dropped.
- Commit (commit_en=1, commit_reg≠0):
  - data[commit_reg] ← commit_data, always;
  - tag[commit_reg] ← TAG_FREE only if tag[commit_reg]==commit_tag. A younger producer keeps ownership.
- Rename (rename_en=1, rename_reg≠0, flush=0): tag[rename_reg] ← rename_tag.
- Same register committed and renamed in one cycle:
  - data is written;
  - the tag ends as rename_tag (rename wins).
- Flush (flush=1):
  - every tag ← TAG_FREE;
  - rename in the same cycle is dropped;
  - commit data write in the same cycle still happens, because the committing instruction is older than the flush point.
- Reads never see a same-cycle rename. The decoder looks up sources before its own destination rename.
- Read ports are independent. Any ports may address the same register.

## Timing
- Commit and rename update state at the edge where they are sampled. Effects are visible on the read ports in the following cycle.
- Flush: all rd_busy=0 in the cycle after the flush edge.
- Read path: zero-latency combinational lookup of the index to the outputs.
- No handshakes. Every valid input is consumed in its cycle; there is no backpressure.
- Reset mid-operation discards all pending tags and data. The first cycle after reset deasserts reads all-zero and all-free.

## Configuration
- REGFILE_BYPASS_EN defined: commit bypass on the read ports.
  - Condition: commit_en=1, commit_reg==rd_name≠0, and tag[commit_reg]==commit_tag.
  - Port response in that same cycle: rd_data=commit_data, rd_tag=TAG_FREE, rd_busy=0.
  - If the stored tag differs (register is owned by a younger producer): rd_data=commit_data, rd_tag=stored tag, rd_busy=1.
  - Bypass is suppressed while rst=1.
- REGFILE_BYPASS_EN undefined:
  - reads reflect registered state only;
  - a commit becomes visible one cycle later;
  - the decoder must tolerate one extra cycle of busy.

## Test plan
- Reset, then read x0..x31 on both ports -> all data 0, TAG_FREE, busy 0. Commit x0 = 0xDEADBEEF and rename x0 tag 3 -> x0 still reads 0, free.
- Rename x5 tag 3; next cycle commit x5 data 0x1234 tag 3 -> x5 reads tag 3, busy 1 until the commit edge, then 0x1234, free. With the bypass macro defined, 0x1234 and free are already visible in the commit cycle.
- Rename x7 tag 2, then x7 tag 6; commit x7 tag 2 data 0xAA -> x7 data 0xAA, tag stays 6, busy 1.
- Same cycle: commit x9 tag 4 data 0x55 (stored tag 4) and rename x9 tag 8 -> next cycle x9 data 0x55, tag 8, busy 1.
- Rename x1..x10 with tags 1..10, then flush together with rename x11 tag 12 and commit x3 tag 3 data 0x77 -> next cycle all busy 0, x11 free, x3 data 0x77.
- Assert rst mid-stream with x4 renamed and a commit pending -> reads 0/free during rst. After rst, x4 reads 0, free, and the pending commit has no effect.

Source files
------------

// File: rtl/rename_regfile_if.sv
// rename_regfile_if: bundle between the decoder / ROB commit stage and the
// rename register file.
//   master : decoder + ROB side (drives flush, commit_*, rename_*, rd_name;
//            receives rd_data, rd_tag, rd_busy)
//   slave  : register file side
// Read port p occupies slice [p*W +: W] of each packed read vector.
interface rename_regfile_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int TAG_W  = 4,
  parameter int NREAD  = 2
);
  logic                    flush;
  logic                    commit_en;
  logic [REG_AW-1:0]       commit_reg;
  logic [DATA_W-1:0]       commit_data;
  logic [TAG_W-1:0]        commit_tag;
  logic                    rename_en;
  logic [REG_AW-1:0]       rename_reg;
  logic [TAG_W-1:0]        rename_tag;
  logic [NREAD*REG_AW-1:0] rd_name;
  logic [NREAD*DATA_W-1:0] rd_data;
  logic [NREAD*TAG_W-1:0]  rd_tag;
  logic [NREAD-1:0]        rd_busy;

  modport master (
    output flush, commit_en, commit_reg, commit_data, commit_tag,
    output rename_en, rename_reg, rename_tag, rd_name,
    input  rd_data, rd_tag, rd_busy
  );

  modport slave (
    input  flush, commit_en, commit_reg, commit_data, commit_tag,
    input  rename_en, rename_reg, rename_tag, rd_name,
    output rd_data, rd_tag, rd_busy
  );
endinterface

// File: rtl/rename_regfile.sv
// rename_regfile: architectural register file with a per-register rename tag
// table. Decoder looks up source operands (data + producer tag + busy) and
// renames destinations; the ROB commit stage writes architectural values.
//   clk  : clock, all state updates on rising edge
//   rst  : synchronous active-high reset (data 0, tags TAG_FREE)
//   bus  : rename_regfile_if.slave (flush, commit_*, rename_*, read ports)
// Register 0 is hard-wired: reads return 0/free, writes and renames dropped.
// Optional feature macro REGFILE_BYPASS_EN: a same-cycle commit is forwarded
// onto matching read ports; without it reads see registered state only.
module rename_regfile #(
  parameter int                DATA_W   = 32,
  parameter int                REG_AW   = 5,
  parameter int                TAG_W    = 4,
  parameter logic [TAG_W-1:0]  TAG_FREE = '0,
  parameter int                NREAD    = 2
) (
  input  logic             clk,
  input  logic             rst,
  rename_regfile_if.slave  bus
);
  localparam int REG_CNT = 2 ** REG_AW;

  logic [DATA_W-1:0] data_q [REG_CNT];
  logic [TAG_W-1:0]  tag_q  [REG_CNT];

  logic [NREAD*DATA_W-1:0] rd_data_c;
  logic [NREAD*TAG_W-1:0]  rd_tag_c;
  logic [NREAD-1:0]        rd_busy_c;
  logic [REG_AW-1:0]       idx_c [NREAD];
  logic [DATA_W-1:0]       dat_c [NREAD];
  logic [TAG_W-1:0]        tg_c  [NREAD];

  // Later assignments in this block take priority: a flush overrides the
  // commit tag release, and a rename overrides it for the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= TAG_FREE;
      end
    end else begin
      if (bus.commit_en && (bus.commit_reg != '0)) begin
        data_q[bus.commit_reg] <= bus.commit_data;
        // Only the producer that still owns the register releases it.
        if (tag_q[bus.commit_reg] == bus.commit_tag)
          tag_q[bus.commit_reg] <= TAG_FREE;
      end
      if (bus.flush) begin
        for (int i = 0; i < REG_CNT; i++)
          tag_q[i] <= TAG_FREE;
      end else if (bus.rename_en && (bus.rename_reg != '0)) begin
        tag_q[bus.rename_reg] <= bus.rename_tag;
      end
    end
  end

  always_comb begin
    rd_data_c = '0;
    rd_tag_c  = '0;
    rd_busy_c = '0;
    for (int p = 0; p < NREAD; p++) begin
      idx_c[p] = bus.rd_name[p*REG_AW +: REG_AW];
      dat_c[p] = data_q[idx_c[p]];
      tg_c[p]  = tag_q[idx_c[p]];
`ifdef REGFILE_BYPASS_EN
      // Forward the committing value; the tag only frees if this commit
      // is the current owner, otherwise the younger producer stays visible.
      if (bus.commit_en && (bus.commit_reg == idx_c[p])) begin
        dat_c[p] = bus.commit_data;
        if (tag_q[idx_c[p]] == bus.commit_tag)
          tg_c[p] = TAG_FREE;
      end
`endif
      if (rst || (idx_c[p] == '0)) begin
        dat_c[p] = '0;
        tg_c[p]  = TAG_FREE;
      end
      rd_data_c[p*DATA_W +: DATA_W] = dat_c[p];
      rd_tag_c[p*TAG_W +: TAG_W]    = tg_c[p];
      rd_busy_c[p]                  = (tg_c[p] != TAG_FREE);
    end
  end

  assign bus.rd_data = rd_data_c;
  assign bus.rd_tag  = rd_tag_c;
  assign bus.rd_busy = rd_busy_c;
endmodule

// File: tb/tb_rename_regfile.sv
// tb_rename_regfile: directed bench for rename_regfile with default
// parameters (32-bit data, 32 registers, 4-bit tags, TAG_FREE=0, 2 ports).
module tb_rename_regfile;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rename_regfile_if #(.DATA_W(32), .REG_AW(5), .TAG_W(4), .NREAD(2)) bus ();

  rename_regfile #(
    .DATA_W(32), .REG_AW(5), .TAG_W(4), .TAG_FREE(4'd0), .NREAD(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp_v);
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush       = 1'b0;
    bus.commit_en   = 1'b0;
    bus.commit_reg  = '0;
    bus.commit_data = '0;
    bus.commit_tag  = '0;
    bus.rename_en   = 1'b0;
    bus.rename_reg  = '0;
    bus.rename_tag  = '0;
  endtask

  // Packed expectation: {data, tag, busy}; busy derived from tag != free.
  task automatic rd2(input string nm,
                     input int r0, input logic [31:0] ed0, input logic [3:0] et0,
                     input int r1, input logic [31:0] ed1, input logic [3:0] et1);
    bus.rd_name = {5'(r1), 5'(r0)};
    #1;
    chk({nm, "_p0"}, {27'd0, bus.rd_data[31:0],  bus.rd_tag[3:0], bus.rd_busy[0]},
                     {27'd0, ed0, et0, (et0 != 4'd0)});
    chk({nm, "_p1"}, {27'd0, bus.rd_data[63:32], bus.rd_tag[7:4], bus.rd_busy[1]},
                     {27'd0, ed1, et1, (et1 != 4'd0)});
  endtask

  task automatic rd1(input string nm, input int r, input logic [31:0] ed, input logic [3:0] et);
    rd2(nm, r, ed, et, r, ed, et);
  endtask

  task automatic do_rename(input int r, input int t);
    bus.rename_en  = 1'b1;
    bus.rename_reg = 5'(r);
    bus.rename_tag = 4'(t);
    tick();
    idle();
  endtask

  task automatic set_commit(input int r, input int t, input logic [31:0] d);
    bus.commit_en   = 1'b1;
    bus.commit_reg  = 5'(r);
    bus.commit_tag  = 4'(t);
    bus.commit_data = d;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus.rd_name = '0;
    #1;
    rd2("rst_hold", 5, 32'h0, 4'd0, 17, 32'h0, 4'd0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state on every register; port 1 walks the opposite direction.
    for (int r = 0; r < 32; r++)
      rd2("reset_all", r, 32'h0, 4'd0, 31 - r, 32'h0, 4'd0);

    // x0 stays hard-wired.
    set_commit(0, 3, 32'hDEAD_BEEF);
    bus.rename_en  = 1'b1;
    bus.rename_reg = 5'd0;
    bus.rename_tag = 4'd3;
    tick();
    idle();
    rd1("x0_wired", 0, 32'h0, 4'd0);

    // Rename then commit by the owner.
    do_rename(5, 3);
    rd1("x5_renamed", 5, 32'h0, 4'd3);
    set_commit(5, 3, 32'h1234);
`ifdef REGFILE_BYPASS_EN
    rd1("x5_commit_cyc", 5, 32'h1234, 4'd0);
`else
    rd1("x5_commit_cyc", 5, 32'h0, 4'd3);
`endif
    tick();
    idle();
    rd1("x5_committed", 5, 32'h1234, 4'd0);

    // Older producer commits; younger keeps ownership.
    do_rename(7, 2);
    do_rename(7, 6);
    set_commit(7, 2, 32'hAA);
    tick();
    idle();
    rd1("x7_younger", 7, 32'hAA, 4'd6);

    // Commit and rename on the same register: rename wins the tag.
    do_rename(9, 4);
    set_commit(9, 4, 32'h55);
    bus.rename_en  = 1'b1;
    bus.rename_reg = 5'd9;
    bus.rename_tag = 4'd8;
    tick();
    idle();
    rd1("x9_same_cyc", 9, 32'h55, 4'd8);

    // Independent ports on different registers.
    rd2("indep", 5, 32'h1234, 4'd0, 7, 32'hAA, 4'd6);

    // Rename x1..x10, then flush with a dropped rename and a live commit.
    for (int r = 1; r <= 10; r++)
      do_rename(r, r);
    rd2("pre_flush", 10, 32'h0, 4'd10, 3, 32'h0, 4'd3);
    bus.flush      = 1'b1;
    bus.rename_en  = 1'b1;
    bus.rename_reg = 5'd11;
    bus.rename_tag = 4'd12;
    set_commit(3, 3, 32'h77);
    tick();
    idle();
    n_tests++;
    for (int r = 0; r < 32; r++) begin
      bus.rd_name = {5'(31 - r), 5'(r)};
      #1;
      if (bus.rd_busy !== 2'b00) begin
        n_fail++;
        $display("FAIL flush_busy r=%0d: got %b expected 00", r, bus.rd_busy);
        break;
      end
    end
    rd2("flush_x3_x11", 3, 32'h77, 4'd0, 11, 32'h0, 4'd0);
    rd2("flush_keep", 5, 32'h1234, 4'd0, 9, 32'h55, 4'd0);

    // Reset mid-stream with a rename outstanding and a commit pending.
    do_rename(4, 5);
    rd1("x4_renamed", 4, 32'h0, 4'd5);
    rst = 1'b1;
    set_commit(4, 5, 32'h99);
    rd2("mid_rst", 4, 32'h0, 4'd0, 7, 32'h0, 4'd0);
    tick();
    rst = 1'b0;
    idle();
    rd2("post_rst", 4, 32'h0, 4'd0, 7, 32'h0, 4'd0);
    rd2("post_rst2", 3, 32'h0, 4'd0, 9, 32'h0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
